uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one uart_tx instance between NUM_REQ byte-stream requesters. It grants the transmitter to one requester at a time and drives that requester's line configuration onto the transmitter's conf input. It passes bytes through with a zero-latency valid/ready handshake. A grant lasts until the requester marks its last byte or MAX_BURST bytes have been sent. The block sits between client logic (command responders, debug printers) and uart_tx.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CONFIG_WIDTH, 8, width of the uart_tx conf word ([7:5] baud select, [1] parity enable, [0] odd parity)
MAX_BURST, 16, maximum bytes per grant before forced rotation (1..255)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_data  in  NUM_REQ*8  byte from each requester; requester i uses bits [8i+7:8i]
req_valid  in  NUM_REQ  byte valid per requester
req_last  in  NUM_REQ  qualifies the current byte as the end of the packet
req_conf  in  NUM_REQ*CONFIG_WIDTH  per-requester uart_tx configuration
req_ready  out  NUM_REQ  byte accepted when req_valid & req_ready
tx_din  out  8  byte to uart_tx din
tx_din_valid  out  1  to uart_tx din_valid
tx_din_ready  in  1  from uart_tx din_ready
tx_conf  out  CONFIG_WIDTH  to uart_tx conf
grant  out  NUM_REQ  one-hot grant; all zero when no requester is granted
busy  out  1  high in any state other than ARB

Behaviour:
- Reset (asynchronous, immediate, including mid-packet) forces:
  - state = ARB
  - grant = 0, busy = 0, req_ready = 0, tx_din_valid = 0
  - tx_conf = 0, rr_ptr = 0, burst_cnt = 0
- The uart_tx frame in flight when reset asserts is not the scheduler's concern.
- States: ARB, SETUP, XFER, DRAIN.
- ARB:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - On a winner: register grant, register tx_conf <= req_conf of the winner, clear burst_cnt, go to SETUP.
  - With no valid requester: stay in ARB.
- SETUP:
  - Exactly one cycle with tx_din_valid = 0, so uart_tx samples the new conf while idle. Then go to XFER.
- XFER, combinational pass-through for granted index g:
  - tx_din = req_data[g]
  - tx_din_valid = req_valid[g]
  - req_ready[g] = tx_din_ready; all other req_ready bits are 0
  - A transfer is tx_din_valid & tx_din_ready. Each transfer increments burst_cnt.
  - The transfer that has req_last[g] = 1, or that brings burst_cnt to MAX_BURST, moves the state to DRAIN.
- tx_conf is held constant from the ARB exit until the next ARB exit; it is never changed in XFER or DRAIN.
- DRAIN:
  - Wait for tx_din_ready = 1, which marks the end of the last frame.
  - On that cycle: set rr_ptr <= (g+1) mod NUM_REQ, clear grant, go to ARB.
- Fairness: a requester cut off by MAX_BURST loses the grant and re-arbitrates behind the others. A requester that keeps req_valid high across grants is served again only after every other valid requester has had a turn.
- If req_valid[g] drops during XFER, stay in XFER and wait. There is no timeout.
- Minimum gap between two grants: DRAIN exit -> ARB (1 cycle) -> SETUP (1 cycle).
- burst_cnt width is 8 bits; MAX_BURST = 1 makes every byte its own grant.
- req_last is ignored unless the byte is actually transferred.

Optional Feature:
UART_TX_SCHED_STATS_EN:
- Defined:
  - Adds output sent_count[15:0], a saturating count of all transfers. It holds at 16'hFFFF.
  - Adds output rotate_count[7:0], a saturating count of grants ended by MAX_BURST rather than req_last.
  - Both counters clear on reset.
- Undefined: neither port nor the counters exist, and the behaviour above is unchanged.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (ARB, SETUP, XFER, DRAIN)
  - the conf field positions: BAUD_SEL_MSB = 7, BAUD_SEL_LSB = 5, PARITY_EN_BIT = 1, PARITY_ODD_BIT = 0
  - the baud select codes 0..7 for 1200..115200
- One sub-module, rr_arbiter: a combinational round-robin search taking (req, ptr) and returning (one-hot winner, found). It is reusable elsewhere.
- Counters and the FSM stay in uart_tx_sched.

Test Plan:
- Single requester 1 sends a 3-byte packet (last on byte 3), conf = 8'hE0:
  - grant = 4'b0010 one cycle after req_valid rises
  - tx_conf = E0 before the first tx_din_valid
  - exactly 3 transfers, then ARB after tx_din_ready returns high
- Requesters 0 and 2 both valid from reset with long packets, MAX_BURST = 4:
  - grants alternate 0, 2, 0, 2, each of exactly 4 bytes
  - rr_ptr advances to 1 then 3
- Requester 3 transfers its byte with req_last=1 while requester 0 is waiting (rr wrap case):
  - next grant goes to requester 0
  - tx_conf switches only after DRAIN and SETUP, never while tx_din_ready = 0
- req_valid[g] deasserts for 10 cycles mid-packet:
  - grant holds, tx_din_valid = 0, no other req_ready is set, and the transfer resumes
- Reset asserted during XFER with a byte pending:
  - grant, req_ready and tx_din_valid go to 0 in the same cycle without a clock edge
  - after release, arbitration restarts from requester 0
- With UART_TX_SCHED_STATS_EN:
  - 70000 single-byte transfers -> sent_count = FFFF
  - 3 forced rotations -> rotate_count = 3

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler state encoding,
// conf word field positions and baud select codes.
package uart_pkg;

    typedef enum logic [1:0] {
        StArb   = 2'd0,
        StSetup = 2'd1,
        StXfer  = 2'd2,
        StDrain = 2'd3
    } sched_state_e;

    localparam int unsigned BAUD_SEL_MSB   = 7;
    localparam int unsigned BAUD_SEL_LSB   = 5;
    localparam int unsigned PARITY_EN_BIT  = 1;
    localparam int unsigned PARITY_ODD_BIT = 0;

    typedef enum logic [2:0] {
        Baud1200   = 3'd0,
        Baud2400   = 3'd1,
        Baud4800   = 3'd2,
        Baud9600   = 3'd3,
        Baud19200  = 3'd4,
        Baud38400  = 3'd5,
        Baud57600  = 3'd6,
        Baud115200 = 3'd7
    } baud_sel_e;

    function automatic baud_sel_e conf_baud_sel(input logic [7:0] conf);
        return baud_sel_e'(conf[BAUD_SEL_MSB:BAUD_SEL_LSB]);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set bit of req at or after ptr,
// wrapping modulo N. Returns a one-hot winner and a found flag.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    winner,
    output logic            found
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte streams.
// Optional UART_TX_SCHED_STATS_EN adds sent_count / rotate_count outputs.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CONFIG_WIDTH = 8,
    parameter int unsigned MAX_BURST    = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ*8-1:0]            req_data,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*CONFIG_WIDTH-1:0] req_conf,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [7:0]                      tx_din,
    output logic                            tx_din_valid,
    input  logic                            tx_din_ready,
    output logic [CONFIG_WIDTH-1:0]         tx_conf,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy
`ifdef UART_TX_SCHED_STATS_EN
    ,
    output logic [15:0]                     sent_count,
    output logic [7:0]                      rotate_count
`endif
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IdxW-1:0]         gidx_q, gidx_d;
    logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CONFIG_WIDTH-1:0] tx_conf_q, tx_conf_d;
    logic [7:0]              burst_cnt_q, burst_cnt_d;

    logic [NUM_REQ-1:0]      win;
    logic                    win_found;
    logic [IdxW-1:0]         win_idx;
    logic [8:0]              burst_inc;
    logic                    xfer;

    rr_arbiter #(
        .N    (NUM_REQ),
        .PtrW (IdxW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .winner (win),
        .found  (win_found)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = IdxW'(i);
        end
    end

    assign burst_inc = {1'b0, burst_cnt_q} + 9'd1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        rr_ptr_d     = rr_ptr_q;
        tx_conf_d    = tx_conf_q;
        burst_cnt_d  = burst_cnt_q;
        req_ready    = '0;
        tx_din       = '0;
        tx_din_valid = 1'b0;
        xfer         = 1'b0;
        unique case (state_q)
            StArb: begin
                if (win_found) begin
                    grant_d     = win;
                    gidx_d      = win_idx;
                    tx_conf_d   = req_conf[win_idx*CONFIG_WIDTH +: CONFIG_WIDTH];
                    burst_cnt_d = '0;
                    state_d     = StSetup;
                end
            end
            // One idle cycle so uart_tx samples the new conf before any byte.
            StSetup: state_d = StXfer;
            StXfer: begin
                tx_din            = req_data[gidx_q*8 +: 8];
                tx_din_valid      = req_valid[gidx_q];
                req_ready[gidx_q] = tx_din_ready;
                xfer              = tx_din_valid & tx_din_ready;
                if (xfer) begin
                    burst_cnt_d = burst_inc[7:0];
                    if (req_last[gidx_q] || burst_inc == 9'(MAX_BURST)) state_d = StDrain;
                end
            end
            StDrain: begin
                if (tx_din_ready) begin
                    rr_ptr_d = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + IdxW'(1);
                    grant_d  = '0;
                    state_d  = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StArb;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            tx_conf_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            tx_conf_q   <= tx_conf_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign tx_conf = tx_conf_q;
    assign busy    = (state_q != StArb);

`ifdef UART_TX_SCHED_STATS_EN
    logic rotated;
    // A byte flagged last ends the grant normally even if it also hits the burst cap.
    assign rotated = xfer & ~req_last[gidx_q] & (burst_inc == 9'(MAX_BURST));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sent_count   <= '0;
            rotate_count <= '0;
        end else begin
            if (xfer && sent_count != 16'hFFFF) sent_count <= sent_count + 16'd1;
            if (rotated && rotate_count != 8'hFF) rotate_count <= rotate_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (NUM_REQ=4, MAX_BURST=4): a cycle table for
// a single packet plus hand sequences for rotation, wrap, stall and reset.
module tb_uart_tx_sched;

    logic        clock;
    logic        reset;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_conf;
    logic [3:0]  req_ready;
    logic [7:0]  tx_din;
    logic        tx_din_valid;
    logic        tx_din_ready;
    logic [7:0]  tx_conf;
    logic [3:0]  grant;
    logic        busy;
`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] sent_count;
    logic [7:0]  rotate_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_sched #(
        .NUM_REQ      (4),
        .CONFIG_WIDTH (8),
        .MAX_BURST    (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_conf     (req_conf),
        .req_ready    (req_ready),
        .tx_din       (tx_din),
        .tx_din_valid (tx_din_valid),
        .tx_din_ready (tx_din_ready),
        .tx_conf      (tx_conf),
        .grant        (grant),
        .busy         (busy)
`ifdef UART_TX_SCHED_STATS_EN
        ,
        .sent_count   (sent_count),
        .rotate_count (rotate_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic [7:0] data;
        logic       ready;
        logic [3:0] e_grant;
        logic       e_busy;
        logic       e_tdv;
        logic [3:0] e_rdy;
        logic [7:0] e_conf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset        = 1'b1;
        req_valid    = '0;
        req_last     = '0;
        tx_din_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Waits for the next grant, then counts transfers until it is released.
    task automatic run_grant(input logic [3:0] exp_grant, input int exp_bytes,
                             input logic [7:0] exp_conf, input logic [1:0] exp_ptr);
        int t;
        int cnt;
        logic conf_ok;
        t = 0;
        while (grant === 4'b0000 && t < 40) begin
            tick;
            t++;
        end
        chk("rr_grant", 32'(grant), 32'(exp_grant));
        cnt     = 0;
        conf_ok = 1'b1;
        t       = 0;
        while (grant !== 4'b0000 && t < 40) begin
            if (tx_din_valid === 1'b1 && tx_din_ready === 1'b1) cnt++;
            if (tx_conf !== exp_conf) conf_ok = 1'b0;
            tick;
            t++;
        end
        chk("rr_release_in_time", 32'(t < 40), 32'd1);
        chk("rr_burst_bytes", 32'(cnt), 32'(exp_bytes));
        chk("rr_conf_stable", 32'(conf_ok), 32'd1);
        chk("rr_ptr", 32'(dut.rr_ptr_q), 32'(exp_ptr));
    endtask

    initial begin
        //           valid    last     data   rdy  grant    busy  tdv   rdy_o    conf
        vecs[0] = '{4'b0010, 4'b0000, 8'hA1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00};
        vecs[1] = '{4'b0010, 4'b0000, 8'hA1, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 8'hE0};
        vecs[2] = '{4'b0010, 4'b0000, 8'hA1, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 8'hE0};
        vecs[3] = '{4'b0010, 4'b0000, 8'hA2, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 8'hE0};
        vecs[4] = '{4'b0010, 4'b0000, 8'hA2, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 8'hE0};
        vecs[5] = '{4'b0010, 4'b0010, 8'hA3, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 8'hE0};
        vecs[6] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 8'hE0};
        vecs[7] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 8'hE0};
        vecs[8] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hE0};

        reset        = 1'b1;
        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        tx_din_ready = 1'b0;
        req_conf     = {8'h62, 8'h43, 8'hE0, 8'h21};
        @(negedge clock);
        #1;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_tdv", 32'(tx_din_valid), 32'd0);
        chk("reset_conf", 32'(tx_conf), 32'd0);
        chk("reset_ptr", 32'(dut.rr_ptr_q), 32'd0);

        // Single 3-byte packet from requester 1, one cycle row per entry.
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            req_valid    = vecs[i].valid;
            req_last     = vecs[i].last;
            req_data     = {8'h00, 8'h00, vecs[i].data, 8'h00};
            tx_din_ready = vecs[i].ready;
            #1;
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_tdv", i), 32'(tx_din_valid), 32'(vecs[i].e_tdv));
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_conf", i), 32'(tx_conf), 32'(vecs[i].e_conf));
            if (vecs[i].e_tdv) chk($sformatf("v%0d_din", i), 32'(tx_din), 32'(vecs[i].data));
            @(negedge clock);
        end
        chk("v_end_ptr", 32'(dut.rr_ptr_q), 32'd2);

        // Requesters 0 and 2 with long packets: forced rotation every 4 bytes.
        req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        do_reset;
        req_valid = 4'b0101;
        #1;
        run_grant(4'b0001, 4, 8'h21, 2'd1);
        run_grant(4'b0100, 4, 8'h43, 2'd3);
        run_grant(4'b0001, 4, 8'h21, 2'd1);
        run_grant(4'b0100, 4, 8'h43, 2'd3);

        // Requester 3 finishes while requester 0 waits: pointer wraps to 0.
        do_reset;
        req_valid = 4'b1000;
        req_last  = 4'b1000;
        #1;
        tick;
        chk("wrap_grant3", 32'(grant), 32'b1000);
        chk("wrap_conf3", 32'(tx_conf), 32'h62);
        req_valid = 4'b1001;
        tick;
        chk("wrap_tdv", 32'(tx_din_valid), 32'd1);
        chk("wrap_req_ready", 32'(req_ready), 32'b1000);
        @(negedge clock);
        tx_din_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("wrap_drain_grant", 32'(grant), 32'b1000);
            chk("wrap_drain_conf", 32'(tx_conf), 32'h62);
            chk("wrap_drain_tdv", 32'(tx_din_valid), 32'd0);
            tick;
        end
        tx_din_ready = 1'b1;
        tick;
        chk("wrap_arb_grant", 32'(grant), 32'd0);
        chk("wrap_arb_conf", 32'(tx_conf), 32'h62);
        chk("wrap_arb_ptr", 32'(dut.rr_ptr_q), 32'd0);
        tick;
        chk("wrap_grant0", 32'(grant), 32'b0001);
        chk("wrap_conf0", 32'(tx_conf), 32'h21);

        // Requester 2 stalls its stream for 10 cycles mid-packet.
        do_reset;
        req_valid = 4'b0100;
        #1;
        tick;
        tick;
        chk("stall_tdv_first", 32'(tx_din_valid), 32'd1);
        chk("stall_din_first", 32'(tx_din), 32'hD2);
        @(negedge clock);
        req_valid = 4'b0001;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_grant", 32'(grant), 32'b0100);
            chk("stall_tdv", 32'(tx_din_valid), 32'd0);
            chk("stall_req_ready", 32'(req_ready), 32'b0100);
            tick;
        end
        req_valid = 4'b0101;
        req_last  = 4'b0100;
        #1;
        chk("stall_resume_tdv", 32'(tx_din_valid), 32'd1);
        chk("stall_resume_din", 32'(tx_din), 32'hD2);
        tick;
        chk("stall_drain_grant", 32'(grant), 32'b0100);
        chk("stall_drain_tdv", 32'(tx_din_valid), 32'd0);
        tick;
        chk("stall_arb_grant", 32'(grant), 32'd0);
        chk("stall_arb_ptr", 32'(dut.rr_ptr_q), 32'd3);

        // From pointer 3 requester 1 wins; reset mid-XFER clears everything at once.
        req_valid    = 4'b0010;
        req_last     = 4'b0000;
        tx_din_ready = 1'b0;
        tick;
        chk("rst_pre_grant", 32'(grant), 32'b0010);
        tick;
        chk("rst_pre_tdv", 32'(tx_din_valid), 32'd1);
        tx_din_ready = 1'b1;
        #1;
        chk("rst_pre_req_ready", 32'(req_ready), 32'b0010);
        #1;
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("rst_async_grant", 32'(grant), 32'd0);
        chk("rst_async_req_ready", 32'(req_ready), 32'd0);
        chk("rst_async_tdv", 32'(tx_din_valid), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick;
        chk("rst_restart_grant", 32'(grant), 32'b0001);

`ifdef UART_TX_SCHED_STATS_EN
        do_reset;
        req_valid = 4'b0001;
        #1;
        run_grant(4'b0001, 4, 8'h21, 2'd1);
        run_grant(4'b0001, 4, 8'h21, 2'd1);
        run_grant(4'b0001, 4, 8'h21, 2'd1);
        chk("stats_rotate", 32'(rotate_count), 32'd3);
        chk("stats_sent", 32'(sent_count), 32'd12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
